// File: rtl/btn_event_if.sv
// Signal bundle between the debouncer side and the gesture classifier.
// master drives en/btn_level and reads events; slave is the classifier.
interface btn_event_if;
  logic en;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;
  logic double_click;
  logic held;

  modport master (
    output en,
    output btn_level,
    input  press_pulse,
    input  release_pulse,
    input  short_press,
    input  long_press,
    input  double_click,
    input  held
  );

  modport slave (
    input  en,
    input  btn_level,
    output press_pulse,
    output release_pulse,
    output short_press,
    output long_press,
    output double_click,
    output held
  );
endinterface

// File: rtl/btn_event.sv
// Button gesture classifier: short / long / double-click plus press/release.
// Ports: clk, rst_n (async low), bus (slave: en, btn_level in; pulses, held out).
module btn_event #(
  parameter int LONG_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 6250000
) (
  input  logic        clk,
  input  logic        rst_n,
  btn_event_if.slave  bus
);

  localparam int MAXC = (LONG_CYCLES > GAP_CYCLES) ?
                        LONG_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = '1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PRESSED   = 3'd1;
  localparam logic [2:0] LONG_HELD = 3'd2;
  localparam logic [2:0] WAIT_GAP  = 3'd3;
  localparam logic [2:0] SECOND    = 3'd4;

  logic [2:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          btn_prev;
  logic          p_n, r_n, s_n, l_n, d_n, h_n;

  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    p_n     = 1'b0;
    r_n     = 1'b0;
    s_n     = 1'b0;
    l_n     = 1'b0;
    d_n     = 1'b0;
    if (!bus.en) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.btn_level && !btn_prev) begin
            p_n     = 1'b1;
            cnt_n   = '0;
            state_n = PRESSED;
          end
        end
        PRESSED: begin
          if (!bus.btn_level) begin
            r_n     = 1'b1;
            cnt_n   = '0;
            state_n = WAIT_GAP;
          end else if (cnt == LONG_LAST) begin
            l_n     = 1'b1;
            state_n = LONG_HELD;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        LONG_HELD: begin
          if (!bus.btn_level) begin
            r_n     = 1'b1;
            state_n = IDLE;
          end
        end
        WAIT_GAP: begin
          // a press on the timeout edge still counts as a double click
          if (bus.btn_level) begin
            d_n     = 1'b1;
            p_n     = 1'b1;
            state_n = SECOND;
          end else if (cnt == GAP_LAST) begin
            s_n     = 1'b1;
            state_n = IDLE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        SECOND: begin
          if (!bus.btn_level) begin
            r_n     = 1'b1;
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign h_n = (state_n == PRESSED) ||
               (state_n == LONG_HELD) ||
               (state_n == SECOND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      btn_prev          <= 1'b1;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.short_press   <= 1'b0;
      bus.long_press    <= 1'b0;
      bus.double_click  <= 1'b0;
      bus.held          <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      btn_prev          <= bus.btn_level;
      bus.press_pulse   <= p_n;
      bus.release_pulse <= r_n;
      bus.short_press   <= s_n;
      bus.long_press    <= l_n;
      bus.double_click  <= d_n;
      bus.held          <= h_n;
    end
  end

endmodule
